serial_shift_engine: RTL and testbench
======================================

# serial_shift_engine

Parametrised full-duplex shift engine: the successor to the plain 8-bit shift register. It loads a transmit word through a valid/ready handshake and shifts it out one bit per peripheral clock edge. At the same time it shifts in a receive word and reports completion with a one-cycle strobe. It sits between the SPI-style peripheral front end, which supplies the edge indicator, and the register/memory side of the design.

## Interface
- width, 8, word length in bits; legal range 2..32
- clk  in  1  FPGA clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- peripheralClkEdge  in  1  single-cycle edge indicator; one shift per asserted cycle while busy
- loadValid  in  1  transmit word offered on parallelDataIn
- loadReady  out  1  engine idle and able to accept a word
- parallelDataIn  in  width  transmit word
- serialDataIn  in  1  receive bit, sampled on shift cycles
- abort  in  1  synchronous cancel of the current word
- lsbFirst  in  1  bit order select; present only with the configuration macro
- serialDataOut  out  1  current transmit bit
- parallelDataOut  out  width  last completed receive word; held until the next completion
- wordValid  out  1  one-cycle strobe: parallelDataOut just updated
- busy  out  1  shifting in progress
- bitCount  out  $clog2(width+1)  edges consumed in current word

## Operation
- States: IDLE, SHIFT. Reset state is IDLE.
- IDLE behaviour:
  - loadReady=1, busy=0, serialDataOut=0.
  - peripheralClkEdge is ignored.
  - loadValid&&loadReady: mem<=parallelDataIn, bitCount<=0, next state SHIFT.
- SHIFT behaviour:
  - loadReady=0, busy=1. loadValid is ignored and no word is accepted.
  - serialDataOut=mem[width-1] (MSB-first) or mem[0] (LSB-first).
  - On each peripheralClkEdge in MSB-first order: mem<={mem[width-2:0],serialDataIn}, bitCount+1.
  - On each peripheralClkEdge in LSB-first order: mem<={serialDataIn,mem[width-1:1]}, bitCount+1.
- Completion:
  - On the edge that takes bitCount from width-1 to width, parallelDataOut<=shifted mem value and wordValid=1 on the next cycle.
  - State returns to IDLE on that same edge. bitCount stays at width until the next load, then clears to 0.
- abort in SHIFT:
  - State goes to IDLE and bitCount goes to 0.
  - No wordValid; parallelDataOut is unchanged.
  - abort overrides a simultaneous peripheralClkEdge, including the final one.
- abort in IDLE has no effect. If abort and loadValid arrive in the same IDLE cycle, the load is accepted.
- Reset mid-word: the word is lost and all outputs return to reset values.
- Reset values: loadReady=1, busy=0, serialDataOut=0, parallelDataOut=0, wordValid=0, bitCount=0, mem=0.

## Timing
- Load accepted in cycle N: busy=1 and serialDataOut=first transmit bit from cycle N+1.
- Bit order only affects which bit is transmitted first; the latency is identical.
- serialDataOut changes only in the cycle after a shift; it is stable between edges.
- Final edge in cycle M: wordValid=1 and loadReady=1 in cycle M+1.
  - A new loadValid in M+1 is accepted, so back-to-back words have zero idle gap.
- Minimum word time is width+1 cycles when an edge arrives every cycle.
- Edges must be at least one cycle apart. Consecutive-cycle edges are legal; each one shifts.

## Configuration
- SERIAL_SHIFT_ENGINE_LSB_SEL_EN defined:
  - lsbFirst port exists.
  - It is sampled only at load acceptance and held for the whole word; changing it mid-word has no effect.
- Macro undefined: no lsbFirst port, and the engine is fixed MSB-first.

## Structure
- Shared package shiftreg_pkg holds:
  - the state enum (IDLE, SHIFT);
  - a bit-count width function returning $clog2(width+1);
  - localparam default width 8.
- One sub-module: shift_bit_counter. It is a parameterised up-counter with clear, increment enable and a terminal-count flag at width-1, and it supplies both bitCount and the completion decision.

## Test plan
- Reset then idle: assert reset mid-cycle, release → all outputs at reset values immediately; loadReady=1; edges in IDLE leave bitCount=0.
- MSB-first exchange, width=8:
  - Stimulus: load 0xA5, feed serialDataIn 1,1,0,0,0,0,1,1 over 8 edges.
  - Response: serialDataOut sequence 1,0,1,0,0,1,0,1; wordValid one cycle after edge 8; parallelDataOut=0xC3.
- LSB-first exchange (macro defined), width=8:
  - Stimulus: load 0xA5 with lsbFirst=1, feed 8 edges.
  - Response: serialDataOut sequence 1,0,1,0,0,1,0,1 read from bit 0 upward; rx bits assembled LSB-first.
- Back-to-back loads:
  - Stimulus: second loadValid held high during the first word.
  - Response: second word is not accepted until the wordValid cycle, then starts with no gap; second word transmitted intact.
- Abort boundary:
  - Stimulus: abort coincident with the 8th edge.
  - Response: no wordValid; parallelDataOut keeps its prior value; bitCount=0; next load proceeds normally.
- Width sweep: width=2 and width=32 with random data and gapped edges → received word equals driven bits and transmitted bits equal the loaded word.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: shared state encoding and sizing helpers for the
// serial_shift_engine and its bit counter.
package shiftreg_pkg;

   // Default word length in bits. Legal range is 2..32.
   localparam int DEFAULT_WIDTH = 8;

   // Engine states: IDLE accepts a word, SHIFT moves bits on peripheral edges.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Width of a counter that must hold every value from 0 to w inclusive.
   function automatic int count_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: counts peripheral edges consumed by the current word.
// Clear has priority over increment. terminal_o flags the count width-1,
// so the caller can tell that the next increment completes the word.
module shift_bit_counter
   import shiftreg_pkg::*;
#(
   parameter  int width = DEFAULT_WIDTH,
   localparam int CW    = count_width(width)
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          inc_i,
   output logic [CW-1:0] count_o,
   output logic          terminal_o
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: clear wins, then increment, otherwise hold.
   always_comb begin
      // NOTE: the default assignment before any branch keeps this block free of inferred latches.
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + CW'(1);
      end
   end

   // Count register with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o    = count_q;
   assign terminal_o = (count_q == CW'(width - 1));

endmodule

// File: rtl/serial_shift_engine.sv
// serial_shift_engine: full-duplex shift engine. A transmit word is loaded
// through a valid/ready handshake and shifted out one bit per peripheral
// edge while a receive word is shifted in; completion raises a one-cycle
// wordValid strobe alongside the updated parallelDataOut.
//
// Optional feature: define SERIAL_SHIFT_ENGINE_LSB_SEL_EN to add the
// lsbFirst port (bit order captured at load). Without it the engine is
// fixed MSB-first.
module serial_shift_engine
   import shiftreg_pkg::*;
#(
   parameter  int width = DEFAULT_WIDTH,
   localparam int CW    = count_width(width)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             peripheralClkEdge,
   input  logic             loadValid,
   output logic             loadReady,
   input  logic [width-1:0] parallelDataIn,
   input  logic             serialDataIn,
   input  logic             abort,
`ifdef SERIAL_SHIFT_ENGINE_LSB_SEL_EN
   input  logic             lsbFirst,
`endif
   output logic             serialDataOut,
   output logic [width-1:0] parallelDataOut,
   output logic             wordValid,
   output logic             busy,
   output logic [CW-1:0]    bitCount
);

   state_e           state_q;
   state_e           state_d;
   logic [width-1:0] mem_q;
   logic [width-1:0] mem_d;
   logic [width-1:0] mem_shifted;
   logic [width-1:0] rx_word_q;
   logic [width-1:0] rx_word_d;
   logic             word_valid_q;
   logic             word_valid_d;
   logic             lsb_sel;
   logic             accept;
   logic             abort_en;
   logic             shift_en;
   logic             terminal;

   // Handshake and edge qualification. abort overrides any edge in SHIFT,
   // including the one that would complete the word.
   assign accept   = (state_q == IDLE) && loadValid;
   assign abort_en = (state_q == SHIFT) && abort;
   assign shift_en = (state_q == SHIFT) && peripheralClkEdge && !abort;

`ifdef SERIAL_SHIFT_ENGINE_LSB_SEL_EN
   logic lsb_sel_q;

   // Bit order is captured once per word; later changes of lsbFirst are ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lsb_sel_q <= 1'b0;
      end else if (accept) begin
         lsb_sel_q <= lsbFirst;
      end
   end

   assign lsb_sel = lsb_sel_q;
`else
   assign lsb_sel = 1'b0;
`endif

   // Edge counter: cleared on load or abort, advanced by each accepted edge.
   shift_bit_counter #(
      .width (width)
   ) u_bit_counter (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (accept || abort_en),
      .inc_i      (shift_en),
      .count_o    (bitCount),
      .terminal_o (terminal)
   );

   // Word after one shift: receive bit enters at the end opposite the transmit bit.
   always_comb begin
      mem_shifted = {mem_q[width-2:0], serialDataIn};
      if (lsb_sel) begin
         mem_shifted = {serialDataIn, mem_q[width-1:1]};
      end
   end

   // Next-state logic for the FSM, shift register and receive output.
   always_comb begin
      state_d      = state_q;
      mem_d        = mem_q;
      rx_word_d    = rx_word_q;
      word_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (loadValid) begin
               state_d = SHIFT;
               mem_d   = parallelDataIn;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (peripheralClkEdge) begin
               mem_d = mem_shifted;
               if (terminal) begin
                  state_d      = IDLE;
                  rx_word_d    = mem_shifted;
                  word_valid_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Engine registers with asynchronous reset; a reset mid-word drops the word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         mem_q        <= '0;
         rx_word_q    <= '0;
         word_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         rx_word_q    <= rx_word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign loadReady       = (state_q == IDLE);
   assign busy            = (state_q == SHIFT);
   assign serialDataOut   = busy && (lsb_sel ? mem_q[0] : mem_q[width-1]);
   assign parallelDataOut = rx_word_q;
   assign wordValid       = word_valid_q;

endmodule

// File: tb/tb_serial_shift_engine.sv
// tb_serial_shift_engine: self-checking bench for serial_shift_engine.
// Three instances (width 8, 2, 32) share stimulus; only the selected one
// is offered loads/aborts. Expected values come from a word-level model:
// transmit bit k is the k-th bit of the loaded word in the chosen order,
// and the received word places driven bit k at its order-dependent position.
`timescale 1ns/1ps
module tb_serial_shift_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        edge_s;
   logic        load_valid;
   logic        sdi;
   logic        abort_s;
   logic        lsb_first;
   logic [31:0] pdi;
   int          sel;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_rx [3];

   logic       rdy8,  sdo8,  wv8,  busy8;
   logic [7:0] pdo8;
   logic [3:0] cnt8;
   logic       rdy2,  sdo2,  wv2,  busy2;
   logic [1:0] pdo2;
   logic [1:0] cnt2;
   logic        rdy32, sdo32, wv32, busy32;
   logic [31:0] pdo32;
   logic [5:0]  cnt32;

   logic        obs_ready, obs_sdo, obs_wv, obs_busy;
   logic [31:0] obs_pdo, obs_cnt;

   always #5 clk = ~clk;

   serial_shift_engine #(.width(8)) u_w8 (
      .clk (clk), .reset (reset), .peripheralClkEdge (edge_s),
      .loadValid (load_valid && sel == 0), .loadReady (rdy8),
      .parallelDataIn (pdi[7:0]), .serialDataIn (sdi), .abort (abort_s && sel == 0),
`ifdef SERIAL_SHIFT_ENGINE_LSB_SEL_EN
      .lsbFirst (lsb_first),
`endif
      .serialDataOut (sdo8), .parallelDataOut (pdo8), .wordValid (wv8),
      .busy (busy8), .bitCount (cnt8)
   );

   serial_shift_engine #(.width(2)) u_w2 (
      .clk (clk), .reset (reset), .peripheralClkEdge (edge_s),
      .loadValid (load_valid && sel == 1), .loadReady (rdy2),
      .parallelDataIn (pdi[1:0]), .serialDataIn (sdi), .abort (abort_s && sel == 1),
`ifdef SERIAL_SHIFT_ENGINE_LSB_SEL_EN
      .lsbFirst (lsb_first),
`endif
      .serialDataOut (sdo2), .parallelDataOut (pdo2), .wordValid (wv2),
      .busy (busy2), .bitCount (cnt2)
   );

   serial_shift_engine #(.width(32)) u_w32 (
      .clk (clk), .reset (reset), .peripheralClkEdge (edge_s),
      .loadValid (load_valid && sel == 2), .loadReady (rdy32),
      .parallelDataIn (pdi), .serialDataIn (sdi), .abort (abort_s && sel == 2),
`ifdef SERIAL_SHIFT_ENGINE_LSB_SEL_EN
      .lsbFirst (lsb_first),
`endif
      .serialDataOut (sdo32), .parallelDataOut (pdo32), .wordValid (wv32),
      .busy (busy32), .bitCount (cnt32)
   );

   always_comb begin
      obs_ready = rdy32; obs_sdo = sdo32; obs_wv = wv32; obs_busy = busy32;
      obs_pdo   = pdo32; obs_cnt = 32'(cnt32);
      if (sel == 0) begin
         obs_ready = rdy8; obs_sdo = sdo8; obs_wv = wv8; obs_busy = busy8;
         obs_pdo   = 32'(pdo8); obs_cnt = 32'(cnt8);
      end else if (sel == 1) begin
         obs_ready = rdy2; obs_sdo = sdo2; obs_wv = wv2; obs_busy = busy2;
         obs_pdo   = 32'(pdo2); obs_cnt = 32'(cnt2);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (width sel %0d): got %0h expected %0h at %0t", tag, sel, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sel(input int s);
      sel = s;
      #1;
   endtask

   function automatic int cur_width();
      return (sel == 0) ? 8 : (sel == 1) ? 2 : 32;
   endfunction

   function automatic bit pick_lsb();
`ifdef SERIAL_SHIFT_ENGINE_LSB_SEL_EN
      return bit'($urandom_range(0, 1));
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_reset_values();
      check("rst_ready", obs_ready, 32'd1);
      check("rst_busy",  obs_busy,  32'd0);
      check("rst_sdo",   obs_sdo,   32'd0);
      check("rst_pdo",   obs_pdo,   32'd0);
      check("rst_wv",    obs_wv,    32'd0);
      check("rst_cnt",   obs_cnt,   32'd0);
   endtask

   // Offer a word in the current (idle) cycle; returns one cycle later.
   task automatic load_word(input logic [31:0] data, input bit lsb, input bit with_abort);
      check("ready_before_load", obs_ready, 32'd1);
      pdi        = data;
      load_valid = 1'b1;
      lsb_first  = lsb;
      abort_s    = with_abort;
      step();
      load_valid = 1'b0;
      abort_s    = 1'b0;
      lsb_first  = ~lsb;
      check("busy_after_load",  obs_busy,  32'd1);
      check("ready_after_load", obs_ready, 32'd0);
      check("cnt_after_load",   obs_cnt,   32'd0);
   endtask

   // Shift a loaded word: checks each transmit bit, optional abort at edge
   // index abort_at, and the completion cycle. pending means loadValid is
   // held high so the next word is taken in the wordValid cycle.
   task automatic shift_word(input logic [31:0] data, input bit lsb, input logic [31:0] rx_bits,
                             input int max_gap, input int abort_at, input bit pending);
      int          w;
      logic [31:0] exp_rx;
      logic        exp_tx;
      w      = cur_width();
      exp_rx = '0;
      for (int k = 0; k < w; k++) begin
         int gap;
         exp_tx = lsb ? data[k] : data[w-1-k];
         check("tx_bit", obs_sdo, exp_tx);
         gap = $urandom_range(0, max_gap);
         for (int g = 0; g < gap; g++) begin
            step();
            check("tx_stable_between_edges", obs_sdo, exp_tx);
            check("cnt_stable_between_edges", obs_cnt, k);
         end
         sdi     = rx_bits[k];
         edge_s  = 1'b1;
         abort_s = (k == abort_at);
         step();
         edge_s  = 1'b0;
         abort_s = 1'b0;
         if (k == abort_at) begin
            check("abort_no_valid", obs_wv,    32'd0);
            check("abort_pdo_held", obs_pdo,   last_rx[sel]);
            check("abort_cnt",      obs_cnt,   32'd0);
            check("abort_idle",     obs_busy,  32'd0);
            check("abort_ready",    obs_ready, 32'd1);
            step();
            check("abort_no_late_valid", obs_wv, 32'd0);
            return;
         end
         exp_rx[lsb ? k : (w-1-k)] = rx_bits[k];
         if (k < w - 1) begin
            check("cnt_mid_word",   obs_cnt,   k + 1);
            check("busy_mid_word",  obs_busy,  32'd1);
            check("ready_mid_word", obs_ready, 32'd0);
            check("no_early_valid", obs_wv,    32'd0);
         end
      end
      check("done_valid", obs_wv,    32'd1);
      check("done_rx",    obs_pdo,   exp_rx);
      check("done_ready", obs_ready, 32'd1);
      check("done_busy",  obs_busy,  32'd0);
      check("done_cnt",   obs_cnt,   w);
      last_rx[sel] = exp_rx;
      step();
      load_valid = 1'b0;
      check("valid_one_cycle", obs_wv,  32'd0);
      check("rx_held",         obs_pdo, exp_rx);
      if (pending) begin
         check("b2b_busy", obs_busy, 32'd1);
         check("b2b_cnt",  obs_cnt,  32'd0);
      end else begin
         check("idle_busy",    obs_busy, 32'd0);
         check("idle_cnt_held", obs_cnt, w);
      end
   endtask

   task automatic random_words(input int s, input int n);
      set_sel(s);
      for (int i = 0; i < n; i++) begin
         logic [31:0] d;
         logic [31:0] r;
         bit          l;
         d = $urandom();
         r = $urandom();
         if (s == 1) d = d & 32'h3;
         if (s == 0) d = d & 32'hFF;
         l = pick_lsb();
         load_word(d, l, 1'b0);
         shift_word(d, l, r, 2, -1, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; edge_s = 1'b0; load_valid = 1'b0; sdi = 1'b0;
      abort_s = 1'b0; lsb_first = 1'b0; pdi = '0; sel = 0;
      for (int s = 0; s < 3; s++) last_rx[s] = '0;

      // Asynchronous reset asserted between clock edges.
      #2 reset = 1'b1;
      #1;
      for (int s = 0; s < 3; s++) begin
         set_sel(s);
         check_reset_values();
      end
      @(posedge clk);
      #3 reset = 1'b0;
      step();
      set_sel(0);

      // Edges in IDLE are ignored.
      edge_s = 1'b1;
      repeat (3) step();
      edge_s = 1'b0;
      check("idle_edge_cnt",  obs_cnt,  32'd0);
      check("idle_edge_busy", obs_busy, 32'd0);
      check("idle_edge_sdo",  obs_sdo,  32'd0);

      // MSB-first 0xA5 exchanged for 1,1,0,0,0,0,1,1 -> 0xC3.
      load_word(32'hA5, 1'b0, 1'b0);
      shift_word(32'hA5, 1'b0, 32'hC3, 0, -1, 1'b0);
      check("msb_rx_C3", obs_pdo, 32'hC3);

`ifdef SERIAL_SHIFT_ENGINE_LSB_SEL_EN
      // LSB-first 0xA5; rx bits 1,0,0,1,1,1,0,0 assemble to 0x39.
      load_word(32'hA5, 1'b1, 1'b0);
      shift_word(32'hA5, 1'b1, 32'h39, 1, -1, 1'b0);
      check("lsb_rx_39", obs_pdo, 32'h39);
`endif

      // Back-to-back: second word offered throughout the first.
      load_word(32'h5A, 1'b0, 1'b0);
      pdi        = 32'h96;
      load_valid = 1'b1;
      lsb_first  = 1'b0;
      shift_word(32'h5A, 1'b0, 32'h0F, 1, -1, 1'b1);
      lsb_first  = 1'b1;
      shift_word(32'h96, 1'b0, 32'hE1, 0, -1, 1'b0);

      // Abort coincident with the final edge, then a normal word.
      load_word(32'h3C, 1'b0, 1'b0);
      shift_word(32'h3C, 1'b0, 32'hFF, 0, 7, 1'b0);
      load_word(32'h81, 1'b0, 1'b0);
      shift_word(32'h81, 1'b0, 32'h6B, 1, -1, 1'b0);

      // Abort mid-word, then abort coincident with a load in IDLE (load wins).
      load_word(32'h77, 1'b0, 1'b0);
      shift_word(32'h77, 1'b0, 32'h00, 1, 3, 1'b0);
      load_word(32'h4E, 1'b0, 1'b1);
      shift_word(32'h4E, 1'b0, 32'hB2, 0, -1, 1'b0);

      // Reset mid-word clears everything, including the held receive word.
      load_word(32'hF0, 1'b0, 1'b0);
      edge_s = 1'b1;
      repeat (3) step();
      edge_s = 1'b0;
      #1 reset = 1'b1;
      #1;
      check_reset_values();
      #1 reset = 1'b0;
      for (int s = 0; s < 3; s++) last_rx[s] = '0;
      step();
      check("post_reset_ready", obs_ready, 32'd1);

      // Width sweep with random data, random order and gapped edges.
      random_words(0, 4);
      random_words(1, 8);
      random_words(2, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
